// File: rtl/cpu_step_ctrl_pkg.sv
// Shared definitions for the CPU execution sequencer and its key debouncer.
package cpu_step_ctrl_pkg;

  // FSM encoding is visible on the state output, so the values are fixed.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_BREAK = 2'b10
  } state_e;

  // 20 ms at 50 MHz for real hardware; simulation uses a short window.
  localparam int unsigned DEB_CYCLES_HW  = 1_000_000;
  localparam int unsigned DEB_CYCLES_SIM = 4;

endpackage

// File: rtl/cpu_step_ctrl_key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle pulse when the debounced level falls (press). Release is silent.
module key_debounce
  import cpu_step_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_HW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press_p
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Stability counter: restarts whenever the synced key agrees with the
  // stable level, and commits the new level after DEB_CYCLES disagreeing cycles.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == LAST) begin
        stable_d = sync2_q;
        press_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchronizer and debounce state; released (high) level after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= key_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_p = press_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Execution sequencer for the single-cycle 8-bit CPU: produces a one-cycle
// datapath enable from manual single-steps, a free-run rate counter, and a
// PC breakpoint that parks the CPU in BREAK until stepped or returned to IDLE.
module cpu_step_ctrl
  import cpu_step_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_HW,
  parameter int unsigned RATE_W     = 26,
  parameter int unsigned PC_W       = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_step_n,
  input  logic              mode_run,
  input  logic              bp_en,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic [RATE_W-1:0] rate_div,
  input  logic [PC_W-1:0]   pc,
  output logic              cpu_en,
  output logic [1:0]        state,
  output logic              halted,
  output logic [CNT_W-1:0]  step_count
);

  logic press_p;

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_key_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n  (key_step_n),
    .press_p(press_p)
  );

  state_e             state_q, state_d;
  logic [RATE_W-1:0]  rcnt_q, rcnt_d;
  logic               cpu_en_q, pulse_d;
  logic [CNT_W-1:0]   step_q;
  logic [RATE_W-1:0]  rate_last;
  logic               terminal;
  logic               bp_hit;

  // A rate of 0 behaves like 1; ">=" lets a lowered rate fire immediately.
  assign rate_last = (rate_div == '0) ? '0 : rate_div - RATE_W'(1);
  assign terminal  = (rcnt_q >= rate_last);
  assign bp_hit    = bp_en && (pc == bp_addr);

  // Next-state and pulse decision; mode_run=0 overrides terminal count and press.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    pulse_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (press_p) pulse_d = 1'b1;
        if (mode_run) begin
          state_d = S_RUN;
          rcnt_d  = '0;
        end
      end
      S_RUN: begin
        if (!mode_run) begin
          state_d = S_IDLE;
          rcnt_d  = '0;
        end else if (terminal) begin
          rcnt_d = '0;
          if (bp_hit) state_d = S_BREAK;
          else        pulse_d = 1'b1;
        end else begin
          rcnt_d = rcnt_q + RATE_W'(1);
        end
      end
      S_BREAK: begin
        if (!mode_run) begin
          state_d = S_IDLE;
        end else if (press_p) begin
          pulse_d = 1'b1;
          state_d = S_RUN;
          rcnt_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        rcnt_d  = '0;
      end
    endcase
  end

  // State, rate counter, registered enable and issued-step counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rcnt_q   <= '0;
      cpu_en_q <= 1'b0;
      step_q   <= '0;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      cpu_en_q <= pulse_d;
      if (pulse_d) step_q <= step_q + CNT_W'(1);
    end
  end

  assign cpu_en     = cpu_en_q;
  assign state      = state_q;
  assign halted     = (state_q == S_BREAK);
  assign step_count = step_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl with a short debounce window.
module tb_cpu_step_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_step_n;
  logic        mode_run;
  logic        bp_en;
  logic [7:0]  bp_addr;
  logic [25:0] rate_div;
  logic [7:0]  pc;
  logic        cpu_en;
  logic [1:0]  state;
  logic        halted;
  logic [15:0] step_count;

  cpu_step_ctrl #(
    .DEB_CYCLES(4), .RATE_W(26), .PC_W(8), .CNT_W(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_step_n(key_step_n),
    .mode_run  (mode_run),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .rate_div  (rate_div),
    .pc        (pc),
    .cpu_en    (cpu_en),
    .state     (state),
    .halted    (halted),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  // Datapath PC model: advances on each enabled clock edge.
  always @(posedge clk) begin
    if (!rst_n)      pc <= 8'd0;
    else if (cpu_en) pc <= pc + 8'd1;
  end

  // Count every cycle in which the enable is observed high.
  int total_pulses = 0;
  always @(negedge clk) if (cpu_en === 1'b1) total_pulses++;

  typedef struct {
    logic        mode_run;
    logic [25:0] rate;
    logic        key_n;
    int          cycles;
    int          exp_pulses;
    logic [1:0]  exp_state;
  } vec_t;

  typedef struct {
    int          pulses;
    logic [1:0]  st;
    logic        hlt;
    logic [15:0] step;
  } exp_t;

  vec_t vecs[22];
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int   step_exp;
    int   base;
    int   n;
    exp_t e;

    // mode, rate, key, cycles, pulses, state
    vecs[0]  = '{1'b0, 26'd3,    1'b1, 5,  0, 2'b00};
    vecs[1]  = '{1'b0, 26'd3,    1'b0, 2,  0, 2'b00};
    vecs[2]  = '{1'b0, 26'd3,    1'b1, 2,  0, 2'b00};
    vecs[3]  = '{1'b0, 26'd3,    1'b0, 2,  0, 2'b00};
    vecs[4]  = '{1'b0, 26'd3,    1'b1, 2,  0, 2'b00};
    vecs[5]  = '{1'b0, 26'd3,    1'b0, 2,  0, 2'b00};
    vecs[6]  = '{1'b0, 26'd3,    1'b1, 2,  0, 2'b00};
    vecs[7]  = '{1'b0, 26'd3,    1'b0, 20, 1, 2'b00};
    vecs[8]  = '{1'b0, 26'd3,    1'b1, 10, 0, 2'b00};
    vecs[9]  = '{1'b0, 26'd3,    1'b0, 10, 1, 2'b00};
    vecs[10] = '{1'b0, 26'd3,    1'b1, 10, 0, 2'b00};
    vecs[11] = '{1'b1, 26'd3,    1'b1, 1,  0, 2'b01};
    vecs[12] = '{1'b1, 26'd3,    1'b1, 12, 4, 2'b01};
    vecs[13] = '{1'b1, 26'd0,    1'b1, 6,  6, 2'b01};
    vecs[14] = '{1'b1, 26'd2,    1'b1, 6,  3, 2'b01};
    vecs[15] = '{1'b1, 26'd5,    1'b1, 3,  0, 2'b01};
    vecs[16] = '{1'b1, 26'd2,    1'b1, 1,  1, 2'b01};
    vecs[17] = '{1'b1, 26'd3,    1'b1, 2,  0, 2'b01};
    vecs[18] = '{1'b0, 26'd3,    1'b1, 1,  0, 2'b00};
    vecs[19] = '{1'b1, 26'd1000, 1'b0, 10, 0, 2'b01};
    vecs[20] = '{1'b1, 26'd1000, 1'b1, 10, 0, 2'b01};
    vecs[21] = '{1'b0, 26'd1000, 1'b1, 2,  0, 2'b00};

    rst_n = 1'b0; key_step_n = 1'b1; mode_run = 1'b0; bp_en = 1'b0;
    bp_addr = 8'h00; rate_div = 26'd3;
    tick(2);
    chk("reset_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("reset_state", {30'd0, state}, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_step", {16'd0, step_count}, 32'd0);
    rst_n = 1'b1;

    step_exp = 0;
    for (int i = 0; i < 22; i++) begin
      mode_run   = vecs[i].mode_run;
      rate_div   = vecs[i].rate;
      key_step_n = vecs[i].key_n;
      step_exp  += vecs[i].exp_pulses;
      sbq.push_back('{vecs[i].exp_pulses, vecs[i].exp_state,
                      (vecs[i].exp_state == 2'b10), 16'(step_exp)});
      base = total_pulses;
      tick(vecs[i].cycles);
      e = sbq.pop_front();
      chk($sformatf("seg%0d_pulses", i), total_pulses - base, e.pulses);
      chk($sformatf("seg%0d_state", i), {30'd0, state}, {30'd0, e.st});
      chk($sformatf("seg%0d_halted", i), {31'd0, halted}, {31'd0, e.hlt});
      chk($sformatf("seg%0d_step", i), {16'd0, step_count}, {16'd0, e.step});
    end

    // Reset in the middle of a run aborts everything.
    mode_run = 1'b1; rate_div = 26'd1;
    tick(5);
    chk("midrun_state", {30'd0, state}, 32'd1);
    rst_n = 1'b0;
    base = total_pulses;
    tick(2);
    chk("midrun_rst_pulses", total_pulses - base, 0);
    chk("midrun_rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("midrun_rst_state", {30'd0, state}, 32'd0);
    chk("midrun_rst_halted", {31'd0, halted}, 32'd0);
    chk("midrun_rst_step", {16'd0, step_count}, 32'd0);

    // Breakpoint at PC 5 with a run step every 2 cycles, from PC 0.
    bp_en = 1'b1; bp_addr = 8'h05; rate_div = 26'd2; mode_run = 1'b1;
    rst_n = 1'b1;
    n = 0;
    while (halted !== 1'b1 && n < 100) begin tick(1); n++; end
    chk("bp_halt_reached", {31'd0, (n < 100)}, 32'd1);
    chk("bp_pc", {24'd0, pc}, 32'h05);
    chk("bp_state", {30'd0, state}, 32'd2);
    chk("bp_step", {16'd0, step_count}, 32'd5);
    base = total_pulses;
    tick(100);
    chk("bp_hold_pulses", total_pulses - base, 0);
    chk("bp_hold_halted", {31'd0, halted}, 32'd1);

    key_step_n = 1'b0;
    n = 0;
    while (cpu_en !== 1'b1 && n < 20) begin tick(1); n++; end
    chk("bp_step_pulse_seen", {31'd0, (n < 20)}, 32'd1);
    chk("bp_resume_state", {30'd0, state}, 32'd1);
    chk("bp_resume_halted", {31'd0, halted}, 32'd0);
    chk("bp_resume_step", {16'd0, step_count}, 32'd6);
    tick(1);
    chk("bp_resume_pc", {24'd0, pc}, 32'h06);
    chk("bp_resume_single", {31'd0, cpu_en}, 32'd0);
    key_step_n = 1'b1;
    tick(9);
    chk("bp_run_continues", {16'd0, step_count}, 32'd11);

    // Halt again, then drop mode_run: BREAK goes straight to IDLE.
    rst_n = 1'b0; bp_addr = 8'h02;
    tick(2);
    rst_n = 1'b1;
    n = 0;
    while (halted !== 1'b1 && n < 50) begin tick(1); n++; end
    chk("bp2_halt_reached", {31'd0, (n < 50)}, 32'd1);
    chk("bp2_pc", {24'd0, pc}, 32'h02);
    mode_run = 1'b0;
    tick(1);
    chk("bp2_drop_state", {30'd0, state}, 32'd0);
    chk("bp2_drop_halted", {31'd0, halted}, 32'd0);
    chk("bp2_drop_cpu_en", {31'd0, cpu_en}, 32'd0);

    // Step counter wraps from FFFF to 0000.
    bp_en = 1'b0; rate_div = 26'd1; mode_run = 1'b1;
    n = 0;
    while (step_count !== 16'hFFFF && n < 70000) begin tick(1); n++; end
    chk("wrap_reached_ffff", {31'd0, (n < 70000)}, 32'd1);
    tick(1);
    chk("wrap_step", {16'd0, step_count}, 32'h0000);
    chk("wrap_cpu_en", {31'd0, cpu_en}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
